// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus stability-counting FSM; d/en/rise/fall settle STABLE_CYCLES+2 edges after raw is first sampled.
// Free-running with no backpressure: every accepted level change produces exactly one en strobe.
module switch_debouncer #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  output logic       d,
  output logic       en,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LO;
      cnt        <= '0;
      d          <= 1'b0;
      en         <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      busy       <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      en   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (s2) begin
            state <= WAIT_HI;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!s2) begin
            state <= IDLE_LO;
            busy  <= 1'b0;
            if (bounce_cnt != 8'hFF) bounce_cnt <= bounce_cnt + 8'd1;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HI;
            busy  <= 1'b0;
            d     <= 1'b1;
            en    <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!s2) begin
            state <= WAIT_LO;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (s2) begin
            state <= IDLE_HI;
            busy  <= 1'b0;
            if (bounce_cnt != 8'hFF) bounce_cnt <= bounce_cnt + 8'd1;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LO;
            busy  <= 1'b0;
            d     <= 1'b0;
            en    <= 1'b1;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE_LO;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
